// File: rtl/control_sequencer.sv
// Hardwired control sequencer for a bus-based CPU: a fetch of three steps
// (T0..T2), then opcode-dependent execute steps, with halt and async clear.
module control_sequencer (
  input  logic        clock_i,
  input  logic        clear_i,
  input  logic [31:0] ir_i,
  input  logic        stop_i,
  output logic        run_o,
  output logic        pc_out_o,
  output logic        pc_in_o,
  output logic        inc_pc_o,
  output logic        mar_in_o,
  output logic        read_o,
  output logic        write_o,
  output logic        mdr_in_o,
  output logic        mdr_out_o,
  output logic        ir_in_o,
  output logic        y_in_o,
  output logic        zlow_in_o,
  output logic        zlow_out_o,
  output logic        gra_o,
  output logic        grb_o,
  output logic        grc_o,
  output logic        rin_o,
  output logic        rout_o,
  output logic        ba_out_o,
  output logic        rc_out_o,
  output logic [3:0]  alu_op_o,
  output logic [3:0]  state_o
);

  typedef enum logic [3:0] {
    S_RESET = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_T7    = 4'd8,
    S_HALT  = 4'd9
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_HALT = 5'b11011;

  state_t     state_q, state_d;
  logic       stop_pend_q, stop_pend_d;
  logic [4:0] opcode;
  logic       unused_ir;
  logic       running;
  logic       is_alu, is_imm, is_ld, is_st, is_mem, long_op;
  logic [3:0] alu_sel;
  logic       last_step;

  assign opcode    = ir_i[31:27];
  assign unused_ir = ^ir_i[26:0];

  always_comb begin
    is_alu  = (opcode == OP_ADD) || (opcode == OP_SUB) ||
              (opcode == OP_AND) || (opcode == OP_OR);
    is_imm  = (opcode == OP_ADDI) || (opcode == OP_LDI);
    is_ld   = (opcode == OP_LD);
    is_st   = (opcode == OP_ST);
    is_mem  = is_ld || is_st;
    long_op = is_alu || is_imm || is_mem;
  end

  always_comb begin
    alu_sel = 4'd0;
    case (opcode)
      OP_SUB:  alu_sel = 4'd1;
      OP_AND:  alu_sel = 4'd2;
      OP_OR:   alu_sel = 4'd3;
      default: alu_sel = 4'd0;
    endcase
  end

  always_comb begin
    running = (state_q == S_T0) || (state_q == S_T1) || (state_q == S_T2) ||
              (state_q == S_T3) || (state_q == S_T4) || (state_q == S_T5) ||
              (state_q == S_T6) || (state_q == S_T7);
  end

  // A stop request seen anywhere inside an instruction is held until the
  // boundary, so a short pulse still halts without truncating the instruction.
  always_comb begin
    state_d     = state_q;
    stop_pend_d = stop_pend_q | (stop_i & running);
    last_step   = 1'b0;
    case (state_q)
      S_RESET: state_d = S_T0;
      S_T0:    state_d = S_T1;
      S_T1:    state_d = S_T2;
      S_T2: begin
        if (opcode == OP_HALT) state_d = S_HALT;
        else if (long_op)      state_d = S_T3;
        else                   last_step = 1'b1;
      end
      S_T3:    state_d = S_T4;
      S_T4:    state_d = S_T5;
      S_T5: begin
        if (is_mem) state_d = S_T6;
        else        last_step = 1'b1;
      end
      S_T6:    state_d = S_T7;
      S_T7:    last_step = 1'b1;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
    if (last_step) state_d = (stop_i || stop_pend_q) ? S_HALT : S_T0;
    if ((state_d == S_T0) || (state_d == S_HALT)) stop_pend_d = 1'b0;
  end

  always_ff @(posedge clock_i or posedge clear_i) begin
    if (clear_i) begin
      state_q     <= S_RESET;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  // Control word is a pure decode of the present state (and opcode from T3 on),
  // so clear drops every strobe in the same cycle it is raised.
  always_comb begin
    pc_out_o   = 1'b0;
    pc_in_o    = 1'b0;
    inc_pc_o   = 1'b0;
    mar_in_o   = 1'b0;
    read_o     = 1'b0;
    write_o    = 1'b0;
    mdr_in_o   = 1'b0;
    mdr_out_o  = 1'b0;
    ir_in_o    = 1'b0;
    y_in_o     = 1'b0;
    zlow_in_o  = 1'b0;
    zlow_out_o = 1'b0;
    gra_o      = 1'b0;
    grb_o      = 1'b0;
    grc_o      = 1'b0;
    rin_o      = 1'b0;
    rout_o     = 1'b0;
    ba_out_o   = 1'b0;
    rc_out_o   = 1'b0;
    alu_op_o   = 4'd0;
    case (state_q)
      S_T0: begin
        pc_out_o  = 1'b1;
        mar_in_o  = 1'b1;
        inc_pc_o  = 1'b1;
        zlow_in_o = 1'b1;
      end
      S_T1: begin
        zlow_out_o = 1'b1;
        pc_in_o    = 1'b1;
        read_o     = 1'b1;
        mdr_in_o   = 1'b1;
      end
      S_T2: begin
        mdr_out_o = 1'b1;
        ir_in_o   = 1'b1;
      end
      S_T3: begin
        if (is_alu || (opcode == OP_ADDI)) begin
          grb_o  = 1'b1;
          rout_o = 1'b1;
          y_in_o = 1'b1;
        end else if ((opcode == OP_LDI) || is_mem) begin
          grb_o    = 1'b1;
          ba_out_o = 1'b1;
          y_in_o   = 1'b1;
        end
      end
      S_T4: begin
        if (is_alu) begin
          grc_o     = 1'b1;
          rout_o    = 1'b1;
          zlow_in_o = 1'b1;
          alu_op_o  = alu_sel;
        end else if (is_imm || is_mem) begin
          rc_out_o  = 1'b1;
          zlow_in_o = 1'b1;
        end
      end
      S_T5: begin
        if (is_alu || is_imm) begin
          zlow_out_o = 1'b1;
          gra_o      = 1'b1;
          rin_o      = 1'b1;
        end else if (is_mem) begin
          zlow_out_o = 1'b1;
          mar_in_o   = 1'b1;
        end
      end
      S_T6: begin
        if (is_ld) begin
          read_o   = 1'b1;
          mdr_in_o = 1'b1;
        end else if (is_st) begin
          gra_o    = 1'b1;
          rout_o   = 1'b1;
          mdr_in_o = 1'b1;
        end
      end
      S_T7: begin
        if (is_ld) begin
          mdr_out_o = 1'b1;
          gra_o     = 1'b1;
          rin_o     = 1'b1;
        end else if (is_st) begin
          write_o = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign run_o   = running;
  assign state_o = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: the driver pushes the hand-written
// expected control word for each cycle; a monitor pops and compares at negedge.
module tb_control_sequencer;

  localparam int W = 28;

  localparam logic [3:0] S_RESET = 4'd0;
  localparam logic [3:0] S_T0    = 4'd1;
  localparam logic [3:0] S_T1    = 4'd2;
  localparam logic [3:0] S_T2    = 4'd3;
  localparam logic [3:0] S_T3    = 4'd4;
  localparam logic [3:0] S_T4    = 4'd5;
  localparam logic [3:0] S_T5    = 4'd6;
  localparam logic [3:0] S_T6    = 4'd7;
  localparam logic [3:0] S_T7    = 4'd8;
  localparam logic [3:0] S_HALT  = 4'd9;

  localparam logic [18:0] PC_OUT   = 19'd1 << 18;
  localparam logic [18:0] PC_IN    = 19'd1 << 17;
  localparam logic [18:0] INC_PC   = 19'd1 << 16;
  localparam logic [18:0] MAR_IN   = 19'd1 << 15;
  localparam logic [18:0] READ     = 19'd1 << 14;
  localparam logic [18:0] WRITE    = 19'd1 << 13;
  localparam logic [18:0] MDR_IN   = 19'd1 << 12;
  localparam logic [18:0] MDR_OUT  = 19'd1 << 11;
  localparam logic [18:0] IR_IN    = 19'd1 << 10;
  localparam logic [18:0] Y_IN     = 19'd1 << 9;
  localparam logic [18:0] ZLOW_IN  = 19'd1 << 8;
  localparam logic [18:0] ZLOW_OUT = 19'd1 << 7;
  localparam logic [18:0] GRA      = 19'd1 << 6;
  localparam logic [18:0] GRB      = 19'd1 << 5;
  localparam logic [18:0] GRC      = 19'd1 << 4;
  localparam logic [18:0] RIN      = 19'd1 << 3;
  localparam logic [18:0] ROUT     = 19'd1 << 2;
  localparam logic [18:0] BA_OUT   = 19'd1 << 1;
  localparam logic [18:0] RC_OUT   = 19'd1 << 0;
  localparam logic [18:0] NONE     = 19'd0;

  localparam logic [31:0] IR_LD    = 32'h0080_0000;
  localparam logic [31:0] IR_LDI   = 32'h0800_0000;
  localparam logic [31:0] IR_ST    = 32'h1000_0000;
  localparam logic [31:0] IR_ADD   = 32'h1800_0000;
  localparam logic [31:0] IR_SUB   = 32'h2000_0000;
  localparam logic [31:0] IR_AND   = 32'h2800_0000;
  localparam logic [31:0] IR_OR    = 32'h3000_0000;
  localparam logic [31:0] IR_ADDI  = 32'h6000_0000;
  localparam logic [31:0] IR_NOP   = 32'hD000_0000;
  localparam logic [31:0] IR_HALT  = 32'hD800_0000;
  localparam logic [31:0] IR_UNDEF = 32'hF800_0000;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] ir;
  logic        stop;
  logic        run_o, pc_out_o, pc_in_o, inc_pc_o, mar_in_o, read_o, write_o;
  logic        mdr_in_o, mdr_out_o, ir_in_o, y_in_o, zlow_in_o, zlow_out_o;
  logic        gra_o, grb_o, grc_o, rin_o, rout_o, ba_out_o, rc_out_o;
  logic [3:0]  alu_op_o, state_o;
  logic [W-1:0] act;

  logic [W-1:0] exp_q[$];
  int           tag_q[$];
  int           step_n   = 0;
  int           checks   = 0;
  int           failures = 0;
  event         probe_ev;

  control_sequencer dut (
    .clock_i(clock), .clear_i(clear), .ir_i(ir), .stop_i(stop),
    .run_o(run_o), .pc_out_o(pc_out_o), .pc_in_o(pc_in_o), .inc_pc_o(inc_pc_o),
    .mar_in_o(mar_in_o), .read_o(read_o), .write_o(write_o), .mdr_in_o(mdr_in_o),
    .mdr_out_o(mdr_out_o), .ir_in_o(ir_in_o), .y_in_o(y_in_o),
    .zlow_in_o(zlow_in_o), .zlow_out_o(zlow_out_o), .gra_o(gra_o), .grb_o(grb_o),
    .grc_o(grc_o), .rin_o(rin_o), .rout_o(rout_o), .ba_out_o(ba_out_o),
    .rc_out_o(rc_out_o), .alu_op_o(alu_op_o), .state_o(state_o)
  );

  // Clock and watchdog
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  assign act = {state_o, run_o, pc_out_o, pc_in_o, inc_pc_o, mar_in_o, read_o,
                write_o, mdr_in_o, mdr_out_o, ir_in_o, y_in_o, zlow_in_o,
                zlow_out_o, gra_o, grb_o, grc_o, rin_o, rout_o, ba_out_o,
                rc_out_o, alu_op_o};

  // Driver tasks
  task automatic push(input logic [3:0] st, input logic [18:0] c, input logic [3:0] alu);
    logic run_e;
    run_e = (st >= S_T0) && (st <= S_T7);
    exp_q.push_back({st, run_e, c, alu});
    tag_q.push_back(step_n);
    step_n++;
  endtask

  task automatic cyc(input logic [3:0] st, input logic [18:0] c, input logic [3:0] alu);
    push(st, c, alu);
    @(posedge clock);
    #1;
  endtask

  task automatic fetch();
    cyc(S_T0, PC_OUT | MAR_IN | INC_PC | ZLOW_IN, 4'd0);
    cyc(S_T1, ZLOW_OUT | PC_IN | READ | MDR_IN, 4'd0);
    cyc(S_T2, MDR_OUT | IR_IN, 4'd0);
  endtask

  task automatic alu_exec(input logic [3:0] alu);
    cyc(S_T3, GRB | ROUT | Y_IN, 4'd0);
    cyc(S_T4, GRC | ROUT | ZLOW_IN, alu);
    cyc(S_T5, ZLOW_OUT | GRA | RIN, 4'd0);
  endtask

  task automatic mem_addr();
    cyc(S_T3, GRB | BA_OUT | Y_IN, 4'd0);
    cyc(S_T4, RC_OUT | ZLOW_IN, 4'd0);
    cyc(S_T5, ZLOW_OUT | MAR_IN, 4'd0);
  endtask

  task automatic reset_pulse();
    clear = 1'b1;
    cyc(S_RESET, NONE, 4'd0);
    clear = 1'b0;
    cyc(S_RESET, NONE, 4'd0);
  endtask

  // Scoreboard monitor
  initial begin : monitor
    logic [W-1:0] e;
    int t;
    forever begin
      @(negedge clock or probe_ev);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        if (act !== e) begin
          failures++;
          $display("FAIL step%0d: state got %0d want %0d, vector got %h want %h",
                   t, act[27:24], e[27:24], act, e);
        end
      end
    end
  end

  // Stimulus
  initial begin
    clear = 1'b1;
    ir    = IR_ADD;
    stop  = 1'b0;
    @(posedge clock);
    #1;
    cyc(S_RESET, NONE, 4'd0);
    cyc(S_RESET, NONE, 4'd0);
    clear = 1'b0;
    cyc(S_RESET, NONE, 4'd0);

    // ADD: six cycles then back to T0
    fetch();
    alu_exec(4'd0);

    // LD: eight cycles, Read in T1 and T6 only, Rin in T7 only
    ir = IR_LD;
    fetch();
    mem_addr();
    cyc(S_T6, READ | MDR_IN, 4'd0);
    cyc(S_T7, MDR_OUT | GRA | RIN, 4'd0);

    // Undefined opcode and NOP: three-cycle fetch only
    ir = IR_UNDEF;
    fetch();
    ir = IR_NOP;
    fetch();

    // LDI uses BAout in T3; ADDI uses Rout
    ir = IR_LDI;
    fetch();
    cyc(S_T3, GRB | BA_OUT | Y_IN, 4'd0);
    cyc(S_T4, RC_OUT | ZLOW_IN, 4'd0);
    cyc(S_T5, ZLOW_OUT | GRA | RIN, 4'd0);
    ir = IR_ADDI;
    fetch();
    cyc(S_T3, GRB | ROUT | Y_IN, 4'd0);
    cyc(S_T4, RC_OUT | ZLOW_IN, 4'd0);
    cyc(S_T5, ZLOW_OUT | GRA | RIN, 4'd0);

    // AND with IR scrambled during T0/T1
    ir = 32'hFFFF_FFFF;
    cyc(S_T0, PC_OUT | MAR_IN | INC_PC | ZLOW_IN, 4'd0);
    ir = 32'h0000_0000;
    cyc(S_T1, ZLOW_OUT | PC_IN | READ | MDR_IN, 4'd0);
    ir = IR_AND;
    cyc(S_T2, MDR_OUT | IR_IN, 4'd0);
    alu_exec(4'd2);

    ir = IR_OR;
    fetch();
    alu_exec(4'd3);

    // SUB with Stop raised in T3: completes, then HALT until clear
    ir = IR_SUB;
    fetch();
    stop = 1'b1;
    alu_exec(4'd1);
    cyc(S_HALT, NONE, 4'd0);
    stop = 1'b0;
    cyc(S_HALT, NONE, 4'd0);
    cyc(S_HALT, NONE, 4'd0);
    reset_pulse();

    // HALT opcode
    ir = IR_HALT;
    fetch();
    cyc(S_HALT, NONE, 4'd0);
    cyc(S_HALT, NONE, 4'd0);
    reset_pulse();

    // ST with clear asserted mid-T7
    ir = IR_ST;
    fetch();
    mem_addr();
    cyc(S_T6, GRA | ROUT | MDR_IN, 4'd0);
    push(S_T7, WRITE, 4'd0);
    @(negedge clock);
    #2;
    clear = 1'b1;
    #1;
    push(S_RESET, NONE, 4'd0);
    -> probe_ev;
    @(posedge clock);
    #1;
    cyc(S_RESET, NONE, 4'd0);
    clear = 1'b0;
    cyc(S_RESET, NONE, 4'd0);

    // Clean restart after abort
    ir = IR_ADD;
    fetch();
    alu_exec(4'd0);

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clock);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 clock  input  1  system clock; all state changes occur on its rising edge.
REQ-002 clear  input  1  asynchronous, active-high reset; forces RESET state immediately.
REQ-003 IR  input  32  instruction register contents from datapath; opcode is IR[31:27].
REQ-004 Stop  input  1  request to halt at the next instruction boundary.
REQ-005 Run  output  1  high while sequencing instructions; low in RESET and HALT.
REQ-006 PCout  output  1  drive PC onto bus.
REQ-007 PCin  output  1  load PC from bus.
REQ-008 IncPC  output  1  ALU computes bus+1.
REQ-009 MARin  output  1  load MAR from bus.
REQ-010 Read  output  1  MDR input mux selects memory data.
REQ-011 Write  output  1  memory write strobe.
REQ-012 MDRin  output  1  load MDR.
REQ-013 MDRout  output  1  drive MDR onto bus.
REQ-014 IRin  output  1  load IR from bus.
REQ-015 Yin  output  1  load Y from bus.
REQ-016 ZLowIn  output  1  load Z low from ALU.
REQ-017 ZLowOut  output  1  drive Z low onto bus.
REQ-018 Gra / Grb / Grc  output  1 each  register-field select (IR ra/rb/rc).
REQ-019 Rin / Rout / BAout  output  1 each  selected register load / drive / drive-with-R0-as-zero.
REQ-020 RCout  output  1  drive sign-extended IR constant onto bus.
REQ-021 ALUop  output  4  ALU function: 0 ADD, 1 SUB, 2 AND, 3 OR; 0 when unused.

Function
REQ-022 States: RESET, T0..T7, HALT; state register 4 bits; all outputs are Moore decodes of present state and IR[31:27], stable for the full cycle.
REQ-023 Exactly one control step per clock; no output asserted outside the steps listed below.
REQ-024 RESET -> T0 on first rising edge with clear low; HALT is absorbing until clear.
REQ-025 Fetch: T0 PCout MARin IncPC ZLowIn; T1 ZLowOut PCin Read MDRin; T2 MDRout IRin.
REQ-026 ADD 00011 / SUB 00100 / AND 00101 / OR 00110: T3 Grb Rout Yin; T4 Grc Rout ZLowIn ALUop=op; T5 ZLowOut Gra Rin; 6 cycles total.
REQ-027 ADDI 01100: T3 Grb Rout Yin; T4 RCout ZLowIn ALUop=0; T5 ZLowOut Gra Rin.
REQ-028 LDI 00001: as ADDI but T3 uses BAout instead of Rout.
REQ-029 LD 00000: T3 Grb BAout Yin; T4 RCout ZLowIn; T5 ZLowOut MARin; T6 Read MDRin; T7 MDRout Gra Rin; 8 cycles.
REQ-030 ST 00010: T3-T5 as LD; T6 Gra Rout MDRin (Read low); T7 Write; 8 cycles.
REQ-031 NOP 11010 and any undefined opcode: T2 -> T0, 3 cycles, no register or memory write.
REQ-032 HALT 11011: T2 -> HALT.
REQ-033 After an instruction's last step: Stop high -> HALT, else -> T0; Stop never truncates an instruction in progress.
REQ-034 IR is sampled only in T3..T7; IR changes during T0..T2 do not affect outputs.
REQ-035 Run high in T0..T7, low otherwise.

Reset
REQ-036 clear high in any state asynchronously forces RESET, all outputs 0 (ALUop 0, Run 0) within the same cycle, aborting any instruction including a pending Write.
REQ-037 Release of clear is recognised only at a rising edge; fetch restarts at T0 with no residual state.

Verification
REQ-038 clear pulse, then IR=ADD (0x18000000) -> T0..T5 sequence per REQ-025/026, ALUop=0 in T4, Run=1, back to T0 after 6 cycles.
REQ-039 IR=LD (0x00800000), Stop=0 -> 8-cycle sequence, Read high only in T1 and T6, Rin only in T7.
REQ-040 IR=ST, clear asserted mid-T7 -> Write drops to 0 immediately, state RESET, Run=0.
REQ-041 IR=SUB with Stop=1 raised in T3 -> instruction completes with ALUop=1 in T4, then HALT, Run=0, stays until clear.
REQ-042 IR opcode 11111 (undefined) -> T0,T1,T2,T0 with no Rin/Write; IR=HALT -> HALT after T2.
REQ-043 IR=LDI: BAout (not Rout) high in T3, RCout in T4, Gra+Rin in T5.
